rom_streamer: RTL and testbench
===============================

ROM_STREAMER -- requirements
Module: rom_streamer

Interface
REQ-001 Parameter VECTOR_LENGTH, default 256: number of ROM words addressable.
REQ-002 Parameter ADDR_WIDTH, default ceil_log2(VECTOR_LENGTH): ROM word address width.
REQ-003 The block SHALL have exactly one clock and one reset; the reset is synchronous and active-high.
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  one-cycle request to begin a stream; sampled only in IDLE.
REQ-007 start_addr_i  in  ADDR_WIDTH  first ROM word address; captured on accepted start_i.
REQ-008 length_i  in  ADDR_WIDTH+1  number of words to stream (0..VECTOR_LENGTH); captured on accepted start_i.
REQ-009 busy_o  out  1  high from accepted start until stream end.
REQ-010 done_o  out  1  one-cycle pulse at stream end.
REQ-011 rom_addr_o  out  ADDR_WIDTH  word address to ROM.
REQ-012 rom_clke_o  out  1  ROM read clock enable; ROM registers data on rising edge when high.
REQ-013 rom_data_i  in  16  ROM read data; valid cycle after rom_clke_o high, held while rom_clke_o low.
REQ-014 out_data_o  out  8  byte stream to downstream (USB CDC IN channel).
REQ-015 out_valid_o  out  1  out_data_o valid.
REQ-016 out_ready_i  in  1  downstream accepts byte when out_valid_o and out_ready_i both high.

Function
REQ-017 States SHALL be IDLE, READ, HI, LO, END.
REQ-018 IDLE: start_i with length_i!=0 -> READ, capture addr_q=start_addr_i, cnt_q=length_i; start_i with length_i==0 -> END; start_i in any other state SHALL be ignored.
REQ-019 READ: rom_clke_o=1, rom_addr_o=addr_q, out_valid_o=0; unconditionally -> HI next cycle.
REQ-020 HI: out_valid_o=1, out_data_o=rom_data_i[15:8]; on handshake -> LO; otherwise hold.
REQ-021 LO: out_valid_o=1, out_data_o=rom_data_i[7:0]; on handshake with cnt_q==1 -> END; on handshake with cnt_q>1 -> HI, addr_q+=1, cnt_q-=1, prefetching next word in the same cycle.
REQ-022 Prefetch: in LO, rom_addr_o SHALL equal addr_q+1 (mod 2^ADDR_WIDTH) and rom_clke_o SHALL equal out_ready_i & (cnt_q>1); all other states except READ drive rom_clke_o=0, rom_addr_o=addr_q.
REQ-023 Address arithmetic wraps modulo 2^ADDR_WIDTH; start_addr_i=VECTOR_LENGTH-1 with length 2 reads last word then word 0.
REQ-024 END: done_o=1 for exactly one cycle, busy_o=0 in END, -> IDLE.
REQ-025 busy_o=1 in READ, HI, LO; 0 in IDLE, END.
REQ-026 Sustained throughput with out_ready_i held high: one byte per cycle after the initial READ cycle; first byte valid 2 cycles after accepted start_i.
REQ-027 out_data_o and out_valid_o SHALL remain stable while out_valid_o=1 and out_ready_i=0 (rom_clke_o stays 0).
REQ-028 out_data_o SHALL be 8'h00 whenever out_valid_o=0.

Reset
REQ-029 rst_i high at a rising edge SHALL force state IDLE, addr_q=0, cnt_q=0 regardless of current state, including mid-stream.
REQ-030 During and after reset: busy_o=0, done_o=0, out_valid_o=0, out_data_o=0, rom_clke_o=0, rom_addr_o=0; no done_o pulse for an aborted stream.

Structure
REQ-031 ceil_log2 SHALL live in the shared common include used by the ROM wrapper; state encodings stay local to this module.
REQ-032 No sub-module; the ROM instance is external and connected at the top level.

Verification
REQ-033 ROM word[0]=16'h6D33, word[1]=16'h1DDB; start_addr 0, length 2, ready=1 -> bytes 6D,33,1D,DB on cycles 2..5 after start, done_o pulse cycle 6.
REQ-034 Same stream with out_ready_i toggling 1,0,0,1,... -> identical byte sequence, data stable during stalls, no extra ROM reads (count rom_clke_o pulses = 2).
REQ-035 start_addr 255, length 2, VECTOR_LENGTH 256 -> rom_addr_o sequence 255 then 0, four bytes output.
REQ-036 length 0 -> no out_valid_o, busy_o stays 0, done_o pulses one cycle after start_i.
REQ-037 rst_i asserted while in LO with ready=0 -> next cycle all outputs 0, no done_o; fresh start_i then streams correctly.
REQ-038 start_i pulsed while busy -> ignored; length 256 full-ROM stream emits 512 bytes, one done_o.

Source files
------------

// File: rtl/rom_streamer_pkg.sv
// Shared helpers for the ROM streamer and the ROM wrapper it feeds from.
// Provides the word/byte widths and the ceil_log2 sizing function.
package rom_streamer_pkg;

  localparam int BYTE_WIDTH = 8;
  localparam int ROM_WIDTH  = 2 * BYTE_WIDTH;

  // Address width needed to index n words; never below one bit.
  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rom_streamer.sv
// Streams length_i 16-bit ROM words as bytes (high byte first) to a
// valid/ready sink, prefetching the next word during the low byte.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin stream (honoured only when idle)
//   start_addr_i          first word address
//   length_i              word count, 0..VECTOR_LENGTH
//   busy_o, done_o        stream active / one-cycle end pulse
//   rom_addr_o            ROM word address
//   rom_clke_o            ROM read enable
//   rom_data_i            ROM word, valid the cycle after a read
//   out_data_o            byte to downstream (0 when not valid)
//   out_valid_o           byte valid
//   out_ready_i           downstream accepts byte
module rom_streamer
  import rom_streamer_pkg::*;
#(
  parameter int VECTOR_LENGTH = 256,
  parameter int ADDR_WIDTH    = ceil_log2(VECTOR_LENGTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [ADDR_WIDTH:0]   length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  output logic                  rom_clke_o,
  input  logic [ROM_WIDTH-1:0]  rom_data_i,
  output logic [BYTE_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_HI,
    S_LO,
    S_END
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  more;
  logic                  hs;

  logic                  busy_d;
  logic                  done_d;
  logic                  valid_d;
  logic [BYTE_WIDTH-1:0] data_d;
  logic                  clke_d;
  logic [ADDR_WIDTH-1:0] raddr_d;

  // Natural overflow gives the modulo-2^ADDR_WIDTH wrap.
  assign addr_inc = addr_q + ADDR_WIDTH'(1);
  assign more     = (cnt_q > CNT_W'(1));
  assign hs       = valid_d & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= start_addr_i;
            cnt_q  <= length_i;
            if (length_i != '0) state_q <= S_READ;
            else                state_q <= S_END;
          end
        end
        S_READ: state_q <= S_HI;
        S_HI: begin
          if (hs) state_q <= S_LO;
        end
        S_LO: begin
          if (hs) begin
            if (more) begin
              addr_q  <= addr_inc;
              cnt_q   <= cnt_q - CNT_W'(1);
              state_q <= S_HI;
            end else begin
              state_q <= S_END;
            end
          end
        end
        S_END:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The LO byte comes from the word still held by the ROM; the next
  // word is fetched only on the accepting cycle so a stall never
  // disturbs the byte on the bus.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    valid_d = 1'b0;
    data_d  = '0;
    clke_d  = 1'b0;
    raddr_d = addr_q;
    unique case (state_q)
      S_READ: begin
        busy_d = 1'b1;
        clke_d = 1'b1;
      end
      S_HI: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        data_d  = rom_data_i[ROM_WIDTH-1 -: BYTE_WIDTH];
      end
      S_LO: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        data_d  = rom_data_i[BYTE_WIDTH-1:0];
        clke_d  = out_ready_i & more;
        raddr_d = addr_inc;
      end
      S_END:   done_d = 1'b1;
      default: ;
    endcase
  end

  // Outputs are forced quiet in the reset cycle itself, so an aborted
  // stream never shows a partial byte or a done pulse.
  assign busy_o      = busy_d  & ~rst_i;
  assign done_o      = done_d  & ~rst_i;
  assign out_valid_o = valid_d & ~rst_i;
  assign rom_clke_o  = clke_d  & ~rst_i;
  assign out_data_o  = rst_i ? '0 : data_d;
  assign rom_addr_o  = rst_i ? '0 : raddr_d;

endmodule

// File: tb/tb_rom_streamer.sv
// Self-checking bench for rom_streamer with a ROM model and a
// byte/address scoreboard built from the stream definition.
module tb_rom_streamer;
  import rom_streamer_pkg::*;

  localparam int VL = 256;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [AW-1:0] saddr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] raddr;
  logic          clke;
  logic [15:0]   rdata = 16'h0000;
  logic [7:0]    odata;
  logic          valid;
  logic          ready;

  rom_streamer #(.VECTOR_LENGTH(VL)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .start_addr_i(saddr),
    .length_i(len),
    .busy_o(busy),
    .done_o(done),
    .rom_addr_o(raddr),
    .rom_clke_o(clke),
    .rom_data_i(rdata),
    .out_data_o(odata),
    .out_valid_o(valid),
    .out_ready_i(ready)
  );

  logic [15:0] mem [VL];
  always @(posedge clk) if (clke) rdata <= mem[raddr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: a stream of l words from a is the bytes hi,lo of
  // mem[(a+i) mod VL], each word read from the ROM exactly once.
  logic [7:0] exp_q[$];
  int         exp_addr[$];

  task automatic load(input int a, input int l);
    logic [15:0] w;
    for (int i = 0; i < l; i++) begin
      w = mem[(a + i) % VL];
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      exp_addr.push_back((a + i) % VL);
    end
  endtask

  // Ready driver: 0 always high, 1 pattern 1,0,0, 2 random, 3 manual.
  int rmode = 0;
  int phase = 0;
  always begin
    @(posedge clk);
    #1;
    case (rmode)
      0: ready = 1'b1;
      1: begin
        ready = (phase % 3 == 0);
        phase++;
      end
      2: ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor / scoreboard.
  bit         mon_en   = 0;
  int         done_cnt = 0;
  bit         pv       = 0;
  bit         pr       = 0;
  logic [7:0] pd       = 8'h00;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (clke) begin
        if (exp_addr.size() == 0) check("rom_read_unexpected", 1, 0);
        else check("rom_addr", 32'(raddr), exp_addr.pop_front());
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) check("byte_unexpected", 32'(odata), 0);
        else check("out_byte", 32'(odata), 32'(exp_q.pop_front()));
      end
      if (!valid) check("data_zero_idle", 32'(odata), 0);
      if (valid && !ready) check("stall_no_read", 32'(clke), 0);
      if (pv && !pr) begin
        check("stall_valid_held", 32'(valid), 1);
        check("stall_data_stable", 32'(odata), 32'(pd));
      end
      if (done) begin
        done_cnt++;
        check("done_not_busy", 32'(busy), 0);
      end
      pv = valid;
      pr = ready;
      pd = odata;
    end else begin
      pv = 0;
      pr = 0;
    end
  end

  typedef struct {
    logic       busy;
    logic       done;
    logic       valid;
    logic [7:0] data;
    logic       clke;
    logic [7:0] addr;
  } cyc_t;

  task automatic cyc_check(input string tag, input cyc_t e);
    @(negedge clk);
    check({tag, ".busy"},  32'(busy),  32'(e.busy));
    check({tag, ".done"},  32'(done),  32'(e.done));
    check({tag, ".valid"}, 32'(valid), 32'(e.valid));
    check({tag, ".data"},  32'(odata), 32'(e.data));
    check({tag, ".clke"},  32'(clke),  32'(e.clke));
    check({tag, ".addr"},  32'(raddr), 32'(e.addr));
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int a, input int l, input int m,
                            input bit poke);
    bit got;
    int budget;
    got    = 0;
    budget = 8 * l + 40;
    rmode  = m;
    load(a, l);
    done_cnt = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    saddr = AW'(a);
    len   = (AW + 1)'(l);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      @(posedge clk);
      #1;
      start = poke && (c == 8);
      if (start) begin
        saddr = AW'($urandom_range(0, VL - 1));
        len   = 3;
      end
    end
    start = 1'b0;
    if (!got) check("stream_timeout", 0, 1);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("stream_bytes_left", exp_q.size(), 0);
    check("stream_reads_left", exp_addr.size(), 0);
    check("stream_done_pulses", done_cnt, 1);
    check("stream_idle_busy", 32'(busy), 0);
    exp_q.delete();
    exp_addr.delete();
  endtask

  typedef struct {
    int a;
    int l;
    int m;
    bit poke;
  } vec_t;

  cyc_t t33[6];
  cyc_t t36[2];
  vec_t vt[7];

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    saddr = '0;
    len   = '0;
    ready = 1'b1;
    for (int i = 0; i < VL; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h6D33;
    mem[1] = 16'h1DDB;

    t33[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0};
    t33[1] = '{1'b1, 1'b0, 1'b1, 8'h6D, 1'b0, 8'd0};
    t33[2] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 8'd1};
    t33[3] = '{1'b1, 1'b0, 1'b1, 8'h1D, 1'b0, 8'd1};
    t33[4] = '{1'b1, 1'b0, 1'b1, 8'hDB, 1'b0, 8'd2};
    t33[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd1};
    t36[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'd9};
    t36[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd9};

    vt[0] = '{0,   2,   1, 1'b0};
    vt[1] = '{255, 2,   0, 1'b0};
    vt[2] = '{255, 2,   2, 1'b0};
    vt[3] = '{0,   0,   0, 1'b0};
    vt[4] = '{10,  1,   2, 1'b0};
    vt[5] = '{128, 20,  1, 1'b1};
    vt[6] = '{0,   256, 2, 1'b1};

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in.busy",  32'(busy),  0);
    check("rst_in.done",  32'(done),  0);
    check("rst_in.valid", 32'(valid), 0);
    check("rst_in.data",  32'(odata), 0);
    check("rst_in.clke",  32'(clke),  0);
    check("rst_in.addr",  32'(raddr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1;
    cyc_check("rst_after", '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0});

    // Cycle-exact two-word stream from address 0.
    rmode = 0;
    load(0, 2);
    start = 1'b1;
    saddr = 0;
    len   = 2;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) cyc_check($sformatf("w2c%0d", i + 1), t33[i]);
    check("w2_bytes_left", exp_q.size(), 0);
    check("w2_reads_left", exp_addr.size(), 0);

    // Zero length: done one cycle after start, never busy.
    saddr = 9;
    len   = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) cyc_check($sformatf("z%0d", i + 1), t36[i]);

    // Reset while stalled in the low byte.
    rmode = 3;
    ready = 1'b1;
    load(5, 4);
    done_cnt = 0;
    saddr = 5;
    len   = 4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(negedge clk);
    check("abort_lo.valid", 32'(valid), 1);
    check("abort_lo.data",  32'(odata), 32'(mem[5][7:0]));
    check("abort_lo.clke",  32'(clke),  0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst.valid", 32'(valid), 0);
    check("abort_rst.busy",  32'(busy),  0);
    check("abort_rst.data",  32'(odata), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr.delete();
    cyc_check("abort_post", '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0});
    cyc_check("abort_idle", '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0});
    check("abort_no_done", done_cnt, 0);
    run_stream(5, 4, 0, 0);

    // Directed table, then randomized streams.
    foreach (vt[i]) run_stream(vt[i].a, vt[i].l, vt[i].m, vt[i].poke);
    for (int i = 0; i < 20; i++)
      run_stream($urandom_range(0, VL - 1), $urandom_range(0, 24),
                 $urandom_range(0, 2), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
